// File: rtl/output_ramp_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : output_ramp_sequencer
// Brief    : Slew-rate-limited setpoint stepper for one DAC output channel.
//            Optional macro RAMP_TRIG_EN adds exttrig as a second start source.
// Revision : 1.0 - initial release
// ============================================================================
module output_ramp_sequencer #(
    parameter logic signed [15:0] INIT_VALUE = 16'sd0,
    parameter int                 INTERVAL_W = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic signed [15:0]      target,
    input  logic        [15:0]      step,
    input  logic [INTERVAL_W-1:0]   interval,
    input  logic                    go,
    input  logic                    abort,
    input  logic                    exttrig,
    output logic signed [15:0]      dac_out,
    output logic                    busy,
    output logic                    done,
    output logic        [31:0]      status
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RAMP = 1'b1
    } state_t;

    state_t                  r_state, w_state_nxt;
    logic                    r_go_d;
    logic signed [15:0]      r_dac, w_dac_nxt;
    logic signed [15:0]      r_tgt, w_tgt_nxt;
    logic        [15:0]      r_step, w_step_nxt;
    logic [INTERVAL_W-1:0]   r_interval, w_interval_nxt;
    logic [INTERVAL_W-1:0]   r_cnt, w_cnt_nxt;
    logic                    r_done, w_done_nxt;
    logic                    r_done_stk, w_done_stk_nxt;
    logic                    r_abort_stk, w_abort_stk_nxt;
    logic                    w_start;

`ifdef RAMP_TRIG_EN
    logic r_trig_d;

    always_ff @(posedge clk) begin
        if (reset) r_trig_d <= 1'b0;
        else       r_trig_d <= exttrig;
    end

    assign w_start = (go & ~r_go_d) | (exttrig & ~r_trig_d);
`else
    logic w_unused_exttrig;
    assign w_unused_exttrig = exttrig;
    assign w_start          = go & ~r_go_d;
`endif

    // Step math is 18 bits wide so dac +/- a full 16-bit step can never wrap
    // before the clamp against the target.
    logic signed [17:0] w_dac_x, w_tgt_x, w_step_x, w_sum_x, w_nxt_x;
    logic               w_up;
    logic signed [15:0] w_step_val;

    always_comb begin
        w_dac_x  = {{2{r_dac[15]}}, r_dac};
        w_tgt_x  = {{2{r_tgt[15]}}, r_tgt};
        w_step_x = {2'b00, r_step};
        w_up     = (r_tgt > r_dac);
        w_sum_x  = w_up ? (w_dac_x + w_step_x) : (w_dac_x - w_step_x);
        if (r_step == 16'd0)
            w_nxt_x = w_tgt_x;
        else if (w_up)
            w_nxt_x = (w_sum_x > w_tgt_x) ? w_tgt_x : w_sum_x;
        else
            w_nxt_x = (w_sum_x < w_tgt_x) ? w_tgt_x : w_sum_x;
        w_step_val = w_nxt_x[15:0];
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_dac_nxt       = r_dac;
        w_tgt_nxt       = r_tgt;
        w_step_nxt      = r_step;
        w_interval_nxt  = r_interval;
        w_cnt_nxt       = r_cnt;
        w_done_nxt      = 1'b0;
        w_done_stk_nxt  = r_done_stk;
        w_abort_stk_nxt = r_abort_stk;

        if (abort) begin
            w_state_nxt = ST_IDLE;
            if (r_state == ST_RAMP) w_abort_stk_nxt = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        if (target != r_dac) begin
                            w_tgt_nxt       = target;
                            w_step_nxt      = step;
                            w_interval_nxt  = interval;
                            w_cnt_nxt       = interval;
                            w_done_stk_nxt  = 1'b0;
                            w_abort_stk_nxt = 1'b0;
                            w_state_nxt     = ST_RAMP;
                        end else begin
                            w_done_nxt     = 1'b1;
                            w_done_stk_nxt = 1'b1;
                        end
                    end
                end
                ST_RAMP: begin
                    if (w_start) begin
                        w_tgt_nxt      = target;
                        w_step_nxt     = step;
                        w_interval_nxt = interval;
                        w_cnt_nxt      = interval;
                    end else if (r_cnt != '0) begin
                        w_cnt_nxt = r_cnt - {{(INTERVAL_W-1){1'b0}}, 1'b1};
                    end else begin
                        w_dac_nxt = w_step_val;
                        w_cnt_nxt = r_interval;
                        if (w_step_val == r_tgt) begin
                            w_state_nxt    = ST_IDLE;
                            w_done_nxt     = 1'b1;
                            w_done_stk_nxt = 1'b1;
                        end
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_go_d      <= 1'b0;
            r_dac       <= INIT_VALUE;
            r_tgt       <= INIT_VALUE;
            r_step      <= 16'd0;
            r_interval  <= '0;
            r_cnt       <= '0;
            r_done      <= 1'b0;
            r_done_stk  <= 1'b0;
            r_abort_stk <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_go_d      <= go;
            r_dac       <= w_dac_nxt;
            r_tgt       <= w_tgt_nxt;
            r_step      <= w_step_nxt;
            r_interval  <= w_interval_nxt;
            r_cnt       <= w_cnt_nxt;
            r_done      <= w_done_nxt;
            r_done_stk  <= w_done_stk_nxt;
            r_abort_stk <= w_abort_stk_nxt;
        end
    end

    assign dac_out = r_dac;
    assign busy    = (r_state == ST_RAMP);
    assign done    = r_done;
    assign status  = {busy, r_done_stk, r_abort_stk, 13'b0, r_dac};

endmodule
`default_nettype wire
